// File: rtl/regfile_pkg.sv
// Shared register-file constants, also imported by the ALU and control blocks.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

    // True when index idx is the hard-wired zero register and that feature is on.
    function automatic logic is_zero_idx(input int idx, input int zero_reg);
        return (zero_reg != 0) && (idx == ZERO_ADDR);
    endfunction

endpackage

// File: rtl/rf_busy_tracker.sv
// Pending-write scoreboard: one busy bit per register, set by lock, cleared by write.
module rf_busy_tracker
    import regfile_pkg::*;
#(
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  int ZERO_REG = 1,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lock_en_i,
    input  logic [ADDR_W-1:0]   lock_addr_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    output logic [NUM_REGS-1:0] busy_d_o,
    output logic [NUM_REGS-1:0] busy_q_o,
    output logic                any_busy_o
);

    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;

    // Next busy vector; a lock beats a same-edge write so the reservation survives.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (is_zero_idx(i, ZERO_REG)) begin
                busy_d[i] = 1'b0;
            end else if (lock_en_i && (lock_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (we_i && (wr_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_d_o   = busy_d;
    assign busy_q_o   = busy_q;
    assign any_busy_o = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with write-first bypass and a per-register
// pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  int ZERO_REG = 1,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    output logic              any_busy
);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_d_s;
    logic [NUM_REGS-1:0] busy_q_s;
    logic                wr_ok_s;
    logic [DATA_W-1:0]   rs_data_d, rs_data_q;
    logic [DATA_W-1:0]   rt_data_d, rt_data_q;
    logic                rs_busy_d, rs_busy_q;
    logic                rt_busy_d, rt_busy_q;

    rf_busy_tracker #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk         (clk),
        .rst_n       (rst_n),
        .lock_en_i   (lock_en),
        .lock_addr_i (lock_addr),
        .we_i        (we),
        .wr_addr_i   (wr_addr),
        .busy_d_o    (busy_d_s),
        .busy_q_o    (busy_q_s),
        .any_busy_o  (any_busy)
    );

    // Value a read port sees this edge: zero register, then bypass, then storage.
    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
        if (is_zero_idx(int'(a), ZERO_REG)) begin
            return '0;
        end else if (we && (a == wr_addr)) begin
            return wr_data;
        end else begin
            return mem_q[a];
        end
    endfunction

    assign wr_ok_s = we && !is_zero_idx(int'(wr_addr), ZERO_REG);

    // Storage array write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok_s) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read-port next state; busy is taken from the post-edge vector so a
    // lock issued alongside the read is already visible.
    always_comb begin
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        rs_busy_d = rs_busy_q;
        rt_busy_d = rt_busy_q;
        if (rd_en) begin
            rs_data_d = read_val(rs_addr);
            rt_data_d = read_val(rt_addr);
            rs_busy_d = busy_d_s[rs_addr];
            rt_busy_d = busy_d_s[rt_addr];
        end else begin
            rs_data_d = rs_data_q;
            rt_data_d = rt_data_q;
            rs_busy_d = rs_busy_q;
            rt_busy_d = rt_busy_q;
        end
    end

    // Read-port output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_data_q <= '0;
            rt_data_q <= '0;
            rs_busy_q <= 1'b0;
            rt_busy_q <= 1'b0;
        end else begin
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            rs_busy_q <= rs_busy_d;
            rt_busy_q <= rt_busy_d;
        end
    end

    assign rs_data = rs_data_q;
    assign rt_data = rt_data_q;
    assign rs_busy = rs_busy_q;
    assign rt_busy = rt_busy_q;

endmodule
